x86_len_decoder: RTL and testbench
==================================

# x86_len_decoder

Byte-serial x86 instruction-length decoder. It consumes the fetch stream one byte per handshake and walks prefixes, the one- or two-byte opcode, ModRM, SIB, displacement and immediate. For each instruction it emits a one-cycle result: total length, opcode, prefix count and error flag. It sits between the fetch byte queue and the opcode decoder and generalises single-word opcode decode to full variable-length framing with operand-size mode.

## Interface
- MAX_LEN, 15: maximum legal instruction length in bytes.
- LEN_W, $clog2(MAX_LEN+1): width of o_len.
- DEFAULT_OP32, 1: 1 = 32-bit default operand size; 0 = 16-bit. Prefix 0x66 toggles it.
- i_clk  in  1  clock.
- i_reset  in  1  reset, synchronous, active-low.
- i_valid  in  1  i_byte is valid.
- i_byte  in  8  next instruction byte.
- o_ready  out  1  byte accepted when i_valid && o_ready.
- o_done  out  1  one-cycle pulse; result outputs valid.
- o_len  out  LEN_W  instruction length in bytes.
- o_opcode  out  16  {8'h0F or 8'h00, opcode byte}.
- o_prefix_cnt  out  LEN_W  number of prefix bytes.
- o_err  out  1  qualifies o_done: unsupported opcode, 0x67 prefix, or length overflow.

## Operation
- States: PREFIX, OP2, MODRM, SIB, DISP, IMM, DONE.
- PREFIX (the reset and idle state):
  - Bytes F0, F2, F3, 26, 2E, 36, 3E, 64, 65, 66 increment the prefix count and stay in PREFIX.
  - 0x66 sets the effective operand size to the opposite of DEFAULT_OP32.
  - 0x67 is an error.
  - 0x0F goes to OP2.
  - Any other byte is the opcode; it is classified and the block moves to the next required field.
- Classification (one-byte opcodes):
  - 00–03 and 88–8B: ModRM, no immediate.
  - 04, 70–7F, EB: imm8.
  - 05, B8–BF, E8, E9: immz.
  - 80, 83: ModRM + imm8.
  - 81: ModRM + immz.
  - 50–5F, 90, C3: no operands.
  - All other opcodes are unsupported → error.
- Classification (two-byte, after 0F):
  - 80–8F: immz.
  - All others: ModRM, no immediate.
- immz is 4 bytes at effective 32-bit operand size, 2 bytes at 16-bit.
- ModRM (32-bit addressing only):
  - mod=11: no displacement.
  - rm=100 and mod≠11: SIB follows.
  - mod=00, rm=101: disp32.
  - mod=01: disp8.
  - mod=10: disp32.
- SIB: when mod=00 and base=101, disp32 follows.
- DISP and IMM use one down-counter of remaining bytes; the block leaves each state when the counter reaches 0.
- Length counter:
  - Increments on every accepted byte.
  - If accepting a byte would make the length exceed MAX_LEN: error, and o_len = MAX_LEN.
  - Otherwise o_len = bytes consumed, including the byte that caused an error.
- Error handling: on any error, move immediately to DONE with o_err=1. No further bytes of that instruction are consumed.
- DONE:
  - o_ready=0 and o_done=1 for exactly one cycle.
  - Then return to PREFIX, clearing the length, prefix count, operand-size override and 0F flag.

## Timing
- Reset values: state PREFIX; o_ready=0 while i_reset=0; all other outputs 0.
- o_ready is 1 in every state except DONE. It is driven from registered state, with no combinational path from i_valid.
- Latency: if the final byte is accepted in cycle N, o_done=1 in cycle N+1.
  - An instruction of L bytes with no bubbles occupies L+1 cycles.
  - The first byte of the next instruction is accepted in cycle N+2.
- i_valid=0 stalls: state and counters hold, and no byte is consumed.
- o_len, o_opcode, o_prefix_cnt and o_err are registered. They are valid only with o_done and hold their values until the next o_done.
- Reset (i_reset=0) mid-instruction: state returns to PREFIX on the next edge, the partial instruction is discarded and no o_done is produced.

## Structure
- Shared package x86_dec_pkg holds:
  - state enum;
  - immediate-kind enum (NONE, IMM8, IMMZ);
  - prefix byte constants;
  - ModRM/SIB field-extraction functions.
- One combinational sub-module, x86_opcode_class:
  - inputs: opcode byte, is_0f flag;
  - outputs: has_modrm, imm_kind, supported.
- The FSM, counters and output registers live in x86_len_decoder.

## Test plan
- 0x90 with i_valid held high → o_done at cycle 2, o_len=1, o_opcode=0x0090, o_err=0.
- 05 78 56 34 12 (DEFAULT_OP32=1) → o_len=5. Then 66 05 34 12 → o_len=4, o_prefix_cnt=1.
- 81 84 88 10 00 00 00 44 33 22 11, with i_valid=0 inserted every other cycle → o_len=11, o_opcode=0x0081, no byte dropped.
- 0F 85 00 01 00 00 → o_len=6, o_opcode=0x0F85. Then 83 C0 01 → o_len=3.
- 15 × 0x66 followed by 0x90 → o_done with o_err=1 and o_len=15 on the 16th byte. Then 0x67 → o_err=1, o_len=1. Then 0xD6 → o_err=1, o_len=1.
- Reset asserted after 81 84 → no o_done; the following 0x90 → o_len=1, o_prefix_cnt=0.

Source files
------------

// File: rtl/x86_dec_pkg.sv
// Shared types, prefix constants and ModRM/SIB field helpers for the x86 length decoder.
package x86_dec_pkg;

    localparam int unsigned CNT_W = 3;

    typedef enum logic [2:0] {
        ST_PREFIX,
        ST_OP2,
        ST_MODRM,
        ST_SIB,
        ST_DISP,
        ST_IMM,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        IMM_NONE,
        IMM_IMM8,
        IMM_IMMZ
    } imm_kind_e;

    localparam logic [7:0] PFX_LOCK  = 8'hF0;
    localparam logic [7:0] PFX_REPNE = 8'hF2;
    localparam logic [7:0] PFX_REP   = 8'hF3;
    localparam logic [7:0] PFX_ES    = 8'h26;
    localparam logic [7:0] PFX_CS    = 8'h2E;
    localparam logic [7:0] PFX_SS    = 8'h36;
    localparam logic [7:0] PFX_DS    = 8'h3E;
    localparam logic [7:0] PFX_FS    = 8'h64;
    localparam logic [7:0] PFX_GS    = 8'h65;
    localparam logic [7:0] PFX_OPSZ  = 8'h66;
    localparam logic [7:0] PFX_ADSZ  = 8'h67;
    localparam logic [7:0] OPC_ESC   = 8'h0F;

    // Prefixes that are simply counted; 0x67 is deliberately excluded.
    function automatic logic is_legacy_prefix(input logic [7:0] b);
        return b inside {PFX_LOCK, PFX_REPNE, PFX_REP, PFX_ES, PFX_CS,
                         PFX_SS, PFX_DS, PFX_FS, PFX_GS, PFX_OPSZ};
    endfunction

    function automatic logic [1:0] modrm_mod(input logic [7:0] b);
        return b[7:6];
    endfunction

    function automatic logic [2:0] modrm_rm(input logic [7:0] b);
        return b[2:0];
    endfunction

    function automatic logic [2:0] sib_base(input logic [7:0] b);
        return b[2:0];
    endfunction

endpackage

// File: rtl/x86_opcode_class.sv
// Combinational opcode classifier: ModRM presence, immediate kind and support flag.
module x86_opcode_class
    import x86_dec_pkg::*;
(
    input  logic [7:0] opcode_i,
    input  logic       is_0f_i,
    output logic       has_modrm_o,
    output imm_kind_e  imm_kind_o,
    output logic       supported_o
);

    always_comb begin
        has_modrm_o = 1'b0;
        imm_kind_o  = IMM_NONE;
        supported_o = 1'b0;
        if (is_0f_i) begin
            // Two-byte map: Jcc rel32 carries immz, everything else takes ModRM.
            supported_o = 1'b1;
            if (opcode_i[7:4] == 4'h8) begin
                imm_kind_o = IMM_IMMZ;
            end else begin
                has_modrm_o = 1'b1;
            end
        end else if (opcode_i inside {[8'h00:8'h03], [8'h88:8'h8B]}) begin
            supported_o = 1'b1;
            has_modrm_o = 1'b1;
        end else if (opcode_i inside {8'h04, [8'h70:8'h7F], 8'hEB}) begin
            supported_o = 1'b1;
            imm_kind_o  = IMM_IMM8;
        end else if (opcode_i inside {8'h05, [8'hB8:8'hBF], 8'hE8, 8'hE9}) begin
            supported_o = 1'b1;
            imm_kind_o  = IMM_IMMZ;
        end else if (opcode_i inside {8'h80, 8'h83}) begin
            supported_o = 1'b1;
            has_modrm_o = 1'b1;
            imm_kind_o  = IMM_IMM8;
        end else if (opcode_i == 8'h81) begin
            supported_o = 1'b1;
            has_modrm_o = 1'b1;
            imm_kind_o  = IMM_IMMZ;
        end else if (opcode_i inside {[8'h50:8'h5F], 8'h90, 8'hC3}) begin
            supported_o = 1'b1;
        end
    end

endmodule

// File: rtl/x86_len_decoder.sv
// Byte-serial x86 instruction-length decoder: frames prefixes, opcode, ModRM, SIB,
// displacement and immediate, and pulses a registered result per instruction.
module x86_len_decoder
    import x86_dec_pkg::*;
#(
    parameter int unsigned MAX_LEN      = 15,
    parameter int unsigned LEN_W        = $clog2(MAX_LEN + 1),
    parameter bit          DEFAULT_OP32 = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_valid,
    input  logic [7:0]       i_byte,
    output logic             o_ready,
    output logic             o_done,
    output logic [LEN_W-1:0] o_len,
    output logic [15:0]      o_opcode,
    output logic [LEN_W-1:0] o_prefix_cnt,
    output logic             o_err
);

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   pfx_q, pfx_d;
    logic               ovr_q, ovr_d;
    logic               is_0f_q, is_0f_d;
    logic [7:0]         opcode_q, opcode_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   imm_len_q, imm_len_d;
    logic [1:0]         mod_q, mod_d;
    logic               err_d;

    logic               ready_q, ready_d;
    logic               done_q, done_d;
    logic [LEN_W-1:0]   res_len_q, res_len_d;
    logic [15:0]        res_opcode_q, res_opcode_d;
    logic [LEN_W-1:0]   res_pfx_q, res_pfx_d;
    logic               res_err_q, res_err_d;

    logic               accept;
    logic               overflow;
    logic               cls_has_modrm;
    imm_kind_e          cls_imm_kind;
    logic               cls_supported;
    logic [CNT_W-1:0]   immz_len;
    logic [CNT_W-1:0]   cls_imm_len;
    logic [CNT_W-1:0]   sib_disp_len;
    logic               take_opcode;

    x86_opcode_class u_class (
        .opcode_i    (i_byte),
        .is_0f_i     (state_q == ST_OP2),
        .has_modrm_o (cls_has_modrm),
        .imm_kind_o  (cls_imm_kind),
        .supported_o (cls_supported)
    );

    assign accept   = i_valid && ready_q;
    assign overflow = accept && (len_q == LEN_W'(MAX_LEN));
    assign immz_len = (DEFAULT_OP32 ^ ovr_q) ? CNT_W'(4) : CNT_W'(2);

    always_comb begin
        case (cls_imm_kind)
            IMM_IMM8: cls_imm_len = CNT_W'(1);
            IMM_IMMZ: cls_imm_len = immz_len;
            default:  cls_imm_len = '0;
        endcase
    end

    always_comb begin
        if (mod_q == 2'b01) begin
            sib_disp_len = CNT_W'(1);
        end else if (mod_q == 2'b10 || sib_base(i_byte) == 3'b101) begin
            sib_disp_len = CNT_W'(4);
        end else begin
            sib_disp_len = '0;
        end
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q <= ST_PREFIX;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and working counters.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        pfx_d       = pfx_q;
        ovr_d       = ovr_q;
        is_0f_d     = is_0f_q;
        opcode_d    = opcode_q;
        cnt_d       = cnt_q;
        imm_len_d   = imm_len_q;
        mod_d       = mod_q;
        err_d       = 1'b0;
        take_opcode = 1'b0;

        if (state_q == ST_DONE) begin
            state_d   = ST_PREFIX;
            len_d     = '0;
            pfx_d     = '0;
            ovr_d     = 1'b0;
            is_0f_d   = 1'b0;
            opcode_d  = '0;
            cnt_d     = '0;
            imm_len_d = '0;
            mod_d     = '0;
        end else if (overflow) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
        end else if (accept) begin
            len_d = len_q + LEN_W'(1);
            case (state_q)
                ST_PREFIX: begin
                    if (is_legacy_prefix(i_byte)) begin
                        pfx_d = pfx_q + LEN_W'(1);
                        if (i_byte == PFX_OPSZ) begin
                            ovr_d = 1'b1;
                        end
                    end else if (i_byte == PFX_ADSZ) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else if (i_byte == OPC_ESC) begin
                        is_0f_d = 1'b1;
                        state_d = ST_OP2;
                    end else begin
                        take_opcode = 1'b1;
                    end
                end
                ST_OP2: take_opcode = 1'b1;
                ST_MODRM: begin
                    mod_d = modrm_mod(i_byte);
                    if (modrm_mod(i_byte) == 2'b11) begin
                        state_d = (imm_len_q != '0) ? ST_IMM : ST_DONE;
                        cnt_d   = imm_len_q;
                    end else if (modrm_rm(i_byte) == 3'b100) begin
                        state_d = ST_SIB;
                    end else if (modrm_mod(i_byte) == 2'b00 && modrm_rm(i_byte) == 3'b101) begin
                        state_d = ST_DISP;
                        cnt_d   = CNT_W'(4);
                    end else if (modrm_mod(i_byte) == 2'b01) begin
                        state_d = ST_DISP;
                        cnt_d   = CNT_W'(1);
                    end else if (modrm_mod(i_byte) == 2'b10) begin
                        state_d = ST_DISP;
                        cnt_d   = CNT_W'(4);
                    end else begin
                        state_d = (imm_len_q != '0) ? ST_IMM : ST_DONE;
                        cnt_d   = imm_len_q;
                    end
                end
                ST_SIB: begin
                    if (sib_disp_len != '0) begin
                        state_d = ST_DISP;
                        cnt_d   = sib_disp_len;
                    end else begin
                        state_d = (imm_len_q != '0) ? ST_IMM : ST_DONE;
                        cnt_d   = imm_len_q;
                    end
                end
                ST_DISP: begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_d == '0) begin
                        state_d = (imm_len_q != '0) ? ST_IMM : ST_DONE;
                        cnt_d   = imm_len_q;
                    end
                end
                ST_IMM: begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_d == '0) begin
                        state_d = ST_DONE;
                    end
                end
                default: state_d = ST_PREFIX;
            endcase

            // Opcode byte: classify and jump to the first operand field.
            if (take_opcode) begin
                opcode_d  = i_byte;
                imm_len_d = cls_imm_len;
                if (!cls_supported) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else if (cls_has_modrm) begin
                    state_d = ST_MODRM;
                end else if (cls_imm_len != '0) begin
                    state_d = ST_IMM;
                    cnt_d   = cls_imm_len;
                end else begin
                    state_d = ST_DONE;
                end
            end
        end
    end

    // Handshake, done pulse and result capture on entry to DONE.
    always_comb begin
        ready_d      = (state_d != ST_DONE);
        done_d       = (state_d == ST_DONE);
        res_len_d    = res_len_q;
        res_opcode_d = res_opcode_q;
        res_pfx_d    = res_pfx_q;
        res_err_d    = res_err_q;
        if (state_d == ST_DONE && state_q != ST_DONE) begin
            res_len_d    = len_d;
            res_opcode_d = {(is_0f_d ? OPC_ESC : 8'h00), opcode_d};
            res_pfx_d    = pfx_d;
            res_err_d    = err_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            len_q        <= '0;
            pfx_q        <= '0;
            ovr_q        <= 1'b0;
            is_0f_q      <= 1'b0;
            opcode_q     <= '0;
            cnt_q        <= '0;
            imm_len_q    <= '0;
            mod_q        <= '0;
            ready_q      <= 1'b0;
            done_q       <= 1'b0;
            res_len_q    <= '0;
            res_opcode_q <= '0;
            res_pfx_q    <= '0;
            res_err_q    <= 1'b0;
        end else begin
            len_q        <= len_d;
            pfx_q        <= pfx_d;
            ovr_q        <= ovr_d;
            is_0f_q      <= is_0f_d;
            opcode_q     <= opcode_d;
            cnt_q        <= cnt_d;
            imm_len_q    <= imm_len_d;
            mod_q        <= mod_d;
            ready_q      <= ready_d;
            done_q       <= done_d;
            res_len_q    <= res_len_d;
            res_opcode_q <= res_opcode_d;
            res_pfx_q    <= res_pfx_d;
            res_err_q    <= res_err_d;
        end
    end

    assign o_ready      = ready_q;
    assign o_done       = done_q;
    assign o_len        = res_len_q;
    assign o_opcode     = res_opcode_q;
    assign o_prefix_cnt = res_pfx_q;
    assign o_err        = res_err_q;

endmodule

// File: tb/tb_x86_len_decoder.sv
// Directed scoreboard bench for x86_len_decoder: expected results are queued per
// instruction and compared on each o_done pulse.
module tb_x86_len_decoder;

    localparam int unsigned LEN_W = 4;

    logic             i_clk = 1'b0;
    logic             i_reset;
    logic             i_valid;
    logic [7:0]       i_byte;
    logic             o_ready;
    logic             o_done;
    logic [LEN_W-1:0] o_len;
    logic [15:0]      o_opcode;
    logic [LEN_W-1:0] o_prefix_cnt;
    logic             o_err;

    typedef struct {
        logic [3:0]  len;
        logic [15:0] op;
        logic [3:0]  pfx;
        logic        err;
        bit          chk_op;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    x86_len_decoder #(.MAX_LEN(15), .LEN_W(LEN_W), .DEFAULT_OP32(1'b1)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_valid      (i_valid),
        .i_byte       (i_byte),
        .o_ready      (o_ready),
        .o_done       (o_done),
        .o_len        (o_len),
        .o_opcode     (o_opcode),
        .o_prefix_cnt (o_prefix_cnt),
        .o_err        (o_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_instr(input logic [3:0] len, input logic [15:0] op,
                                input logic [3:0] pfx, input logic err, input bit chk_op);
        exp_t e;
        e.len = len; e.op = op; e.pfx = pfx; e.err = err; e.chk_op = chk_op;
        sb.push_back(e);
    endtask

    // Present one byte and return right after the edge that accepts it.
    task automatic send(input logic [7:0] b);
        int guard = 0;
        @(negedge i_clk);
        i_valid = 1'b1;
        i_byte  = b;
        while (!o_ready && guard < 50) begin
            @(negedge i_clk);
            guard++;
        end
        if (guard >= 50) chk("ready_timeout", 32'(o_ready), 32'd1);
        @(posedge i_clk);
    endtask

    task automatic send_bubble(input logic [7:0] b);
        send(b);
        @(negedge i_clk);
        i_valid = 1'b0;
    endtask

    task automatic idle();
        @(negedge i_clk);
        i_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int guard = 0;
        idle();
        while (sb.size() != 0 && guard < 40) begin
            @(negedge i_clk);
            guard++;
        end
        chk(tag, 32'(sb.size()), 32'd0);
    endtask

    // Scoreboard check on every done pulse.
    always @(negedge i_clk) begin
        if (o_done) begin
            chk("ready_low_in_done", 32'(o_ready), 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'(o_done), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("len", 32'(o_len), 32'(e.len));
                chk("prefix_cnt", 32'(o_prefix_cnt), 32'(e.pfx));
                chk("err", 32'(o_err), 32'(e.err));
                if (e.chk_op) chk("opcode", 32'(o_opcode), 32'(e.op));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset = 1'b0;
        i_valid = 1'b0;
        i_byte  = 8'h00;
        repeat (3) @(negedge i_clk);
        chk("rst_ready", 32'(o_ready), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_len", 32'(o_len), 32'd0);
        chk("rst_opcode", 32'(o_opcode), 32'd0);
        chk("rst_pfx", 32'(o_prefix_cnt), 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);
        i_reset = 1'b1;

        // NOP: done on the cycle after acceptance, ready again the cycle after.
        expect_instr(4'd1, 16'h0090, 4'd0, 1'b0, 1'b1);
        send(8'h90);
        @(negedge i_clk);
        i_valid = 1'b0;
        chk("nop_latency_done", 32'(o_done), 32'd1);
        @(negedge i_clk);
        chk("nop_ready_back", 32'(o_ready), 32'd1);
        chk("nop_done_one_cycle", 32'(o_done), 32'd0);
        chk("len_hold", 32'(o_len), 32'd1);

        // immz at 32-bit, then with operand-size override.
        expect_instr(4'd5, 16'h0005, 4'd0, 1'b0, 1'b1);
        send(8'h05); send(8'h78); send(8'h56); send(8'h34); send(8'h12);
        expect_instr(4'd4, 16'h0005, 4'd1, 1'b0, 1'b1);
        send(8'h66); send(8'h05); send(8'h34); send(8'h12);
        drain("drain_immz");

        // ModRM+SIB+disp32+imm32 with bubbles between every byte.
        expect_instr(4'd11, 16'h0081, 4'd0, 1'b0, 1'b1);
        send_bubble(8'h81); send_bubble(8'h84); send_bubble(8'h88);
        send_bubble(8'h10); send_bubble(8'h00); send_bubble(8'h00); send_bubble(8'h00);
        send_bubble(8'h44); send_bubble(8'h33); send_bubble(8'h22); send_bubble(8'h11);
        drain("drain_bubbles");

        // Two-byte Jcc, then ModRM reg form with imm8.
        expect_instr(4'd6, 16'h0F85, 4'd0, 1'b0, 1'b1);
        send(8'h0F); send(8'h85); send(8'h00); send(8'h01); send(8'h00); send(8'h00);
        expect_instr(4'd3, 16'h0083, 4'd0, 1'b0, 1'b1);
        send(8'h83); send(8'hC0); send(8'h01);
        drain("drain_jcc");

        // Addressing variants and a few more opcode classes.
        expect_instr(4'd4, 16'h008B, 4'd0, 1'b0, 1'b1);
        send(8'h8B); send(8'h44); send(8'h24); send(8'h08);
        expect_instr(4'd7, 16'h008B, 4'd0, 1'b0, 1'b1);
        send(8'h8B); send(8'h04); send(8'h25);
        send(8'h00); send(8'h10); send(8'h00); send(8'h00);
        expect_instr(4'd6, 16'h0001, 4'd0, 1'b0, 1'b1);
        send(8'h01); send(8'h05); send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
        expect_instr(4'd3, 16'h0FAF, 4'd0, 1'b0, 1'b1);
        send(8'h0F); send(8'hAF); send(8'hC0);
        expect_instr(4'd2, 16'h0070, 4'd0, 1'b0, 1'b1);
        send(8'h70); send(8'h10);
        expect_instr(4'd4, 16'h00B8, 4'd1, 1'b0, 1'b1);
        send(8'h66); send(8'hB8); send(8'h34); send(8'h12);
        expect_instr(4'd3, 16'h0090, 4'd2, 1'b0, 1'b1);
        send(8'h2E); send(8'h3E); send(8'h90);
        drain("drain_variants");

        // Length overflow on the 16th byte, 0x67 and an unsupported opcode.
        expect_instr(4'd15, 16'h0000, 4'd15, 1'b1, 1'b0);
        for (int i = 0; i < 15; i++) send(8'h66);
        send(8'h90);
        expect_instr(4'd1, 16'h0000, 4'd0, 1'b1, 1'b0);
        send(8'h67);
        expect_instr(4'd1, 16'h0000, 4'd0, 1'b1, 1'b0);
        send(8'hD6);
        drain("drain_errors");

        // Reset mid-instruction discards the partial frame.
        send(8'h81); send(8'h84);
        @(negedge i_clk);
        i_valid = 1'b0;
        i_reset = 1'b0;
        repeat (3) begin
            @(negedge i_clk);
            chk("midrst_no_done", 32'(o_done), 32'd0);
        end
        chk("midrst_ready", 32'(o_ready), 32'd0);
        i_reset = 1'b1;
        expect_instr(4'd1, 16'h0090, 4'd0, 1'b0, 1'b1);
        send(8'h90);
        drain("drain_after_reset");

        repeat (3) @(negedge i_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
